// File: rtl/host_cmd_queue.sv
// Host request front end for the DDR3 controller.
// In-order issue with permit gating and read-tag return.
module host_cmd_queue #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int DQ_BITS   = 8,
  parameter int REQ_DEPTH = 8,
  parameter int RD_MAX    = 8,
  parameter int ID_BITS   = 4
) (
  input  logic                          clk,
  input  logic                          power_on_rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [BA_BITS-1:0]            req_bank,
  input  logic [ADDR_BITS-1:0]          req_row,
  input  logic [ADDR_BITS-1:0]          req_col,
  input  logic [DQ_BITS*8-1:0]          req_wdata,
  input  logic [ID_BITS-1:0]            req_id,
  output logic [BA_BITS+2*ADDR_BITS+2:0] command,
  output logic                          valid,
  input  logic [3:0]                    ba_cmd_pm,
  output logic [DQ_BITS*8-1:0]          write_data,
  input  logic [DQ_BITS*8-1:0]          read_data,
  input  logic                          read_data_valid,
  output logic                          rsp_valid,
  output logic [DQ_BITS*8-1:0]          rsp_rdata,
  output logic [ID_BITS-1:0]            rsp_id,
  output logic                          err_underflow
);

  localparam int DW = DQ_BITS * 8;
  localparam int RA = $clog2(REQ_DEPTH);
  localparam int TA = $clog2(RD_MAX);
  localparam int CW = BA_BITS + 2 * ADDR_BITS + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic                 q_w    [REQ_DEPTH];
  logic [BA_BITS-1:0]   q_bank [REQ_DEPTH];
  logic [ADDR_BITS-1:0] q_row  [REQ_DEPTH];
  logic [ADDR_BITS-1:0] q_col  [REQ_DEPTH];
  logic [DW-1:0]        q_data [REQ_DEPTH];
  logic [ID_BITS-1:0]   q_id   [REQ_DEPTH];

  logic [RA-1:0] q_wp, q_rp;
  logic [RA:0]   q_cnt;
  logic          rdy_en;
  logic          q_push, q_pop, q_empty, q_full;

  logic [ID_BITS-1:0] t_mem [RD_MAX];
  logic [TA-1:0]      t_wp, t_rp;
  logic [TA:0]        rd_out;
  logic               issue_rd, rd_acc;
  logic [ID_BITS-1:0] t_head;

  logic                 h_w;
  logic [BA_BITS-1:0]   h_bank;
  logic [ADDR_BITS-1:0] h_row, h_col;
  logic [DW-1:0]        h_data;
  logic [ID_BITS-1:0]   h_id;
  logic [CW-1:0]        h_cmd;
  logic [1:0]           pidx;
  logic                 can_go, load;

  assign q_full    = q_cnt == (RA+1)'(REQ_DEPTH);
  assign q_empty   = q_cnt == '0;
  assign req_ready = rdy_en && !q_full;
  assign q_push    = req_valid && req_ready;
  assign q_pop     = state == ISSUE;

  assign h_w    = q_w[q_rp];
  assign h_bank = q_bank[q_rp];
  assign h_row  = q_row[q_rp];
  assign h_col  = q_col[q_rp];
  assign h_data = q_data[q_rp];
  assign h_id   = q_id[q_rp];
  assign h_cmd  = {h_w, h_bank, h_row, h_col, 2'b00};
  assign pidx   = h_bank[BA_BITS-1 -: 2];

  assign can_go = !q_empty && ba_cmd_pm[pidx] &&
                  (h_w || rd_out < (TA+1)'(RD_MAX));

  assign issue_rd = q_pop && !h_w;
  assign rd_acc   = read_data_valid &&
                    (rd_out != '0 || issue_rd);
  // empty tag FIFO with a read issuing: bypass its id
  assign t_head   = (rd_out == '0) ? h_id : t_mem[t_rp];

  // request FIFO storage
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_w[q_wp]    <= req_write;
      q_bank[q_wp] <= req_bank;
      q_row[q_wp]  <= req_row;
      q_col[q_wp]  <= req_col;
      q_data[q_wp] <= req_wdata;
      q_id[q_wp]   <= req_id;
    end
  end

  // request FIFO pointers, count and ready enable
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      q_wp   <= '0;
      q_rp   <= '0;
      q_cnt  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (q_push) q_wp <= q_wp + 1'b1;
      if (q_pop)  q_rp <= q_rp + 1'b1;
      unique case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // tag FIFO storage
  always_ff @(posedge clk) begin
    if (issue_rd) t_mem[t_wp] <= h_id;
  end

  // tag FIFO pointers and outstanding-read count
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      t_wp   <= '0;
      t_rp   <= '0;
      rd_out <= '0;
    end else begin
      if (issue_rd) t_wp <= t_wp + 1'b1;
      if (rd_acc)   t_rp <= t_rp + 1'b1;
      unique case ({issue_rd, rd_acc})
        2'b10:   rd_out <= rd_out + 1'b1;
        2'b01:   rd_out <= rd_out - 1'b1;
        default: rd_out <= rd_out;
      endcase
    end
  end

  // issue FSM state register
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) state <= IDLE;
    else                 state <= state_nx;
  end

  // next state; GAP re-checks the head so issue peaks at 1 per 2 cycles
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE:    state_nx = can_go ? ISSUE : IDLE;
      ISSUE:   state_nx = GAP;
      GAP:     state_nx = can_go ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: strobe in ISSUE, capture head when entering it
  always_comb begin
    valid = 1'b0;
    load  = 1'b0;
    unique case (state)
      ISSUE:   valid = 1'b1;
      IDLE:    load  = can_go;
      GAP:     load  = can_go;
      default: load  = 1'b0;
    endcase
  end

  // command and write data hold between issues
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      command    <= '0;
      write_data <= '0;
    end else if (load) begin
      command <= h_cmd;
      if (h_w) write_data <= h_data;
    end
  end

  // read response and sticky underflow flag
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_id        <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp_valid <= rd_acc;
      if (rd_acc) begin
        rsp_rdata <= read_data;
        rsp_id    <= t_head;
      end
      if (read_data_valid && !rd_acc) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_host_cmd_queue.sv
// Scoreboard bench for host_cmd_queue.
// Checks issue order, spacing, permits and read tags.
module tb_host_cmd_queue;

  logic        clk = 1'b0;
  logic        power_on_rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_bank;
  logic [13:0] req_row, req_col;
  logic [63:0] req_wdata;
  logic [3:0]  req_id;
  logic [33:0] command;
  logic        valid;
  logic [3:0]  ba_cmd_pm;
  logic [63:0] write_data, read_data, rsp_rdata;
  logic        read_data_valid, rsp_valid, err_underflow;
  logic [3:0]  rsp_id;

  always #5 clk = ~clk;

  host_cmd_queue dut (
    .clk             (clk),
    .power_on_rst_n  (power_on_rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_bank        (req_bank),
    .req_row         (req_row),
    .req_col         (req_col),
    .req_wdata       (req_wdata),
    .req_id          (req_id),
    .command         (command),
    .valid           (valid),
    .ba_cmd_pm       (ba_cmd_pm),
    .write_data      (write_data),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_id          (rsp_id),
    .err_underflow   (err_underflow)
  );

  typedef struct {
    logic        w;
    logic [33:0] cmd;
    logic [63:0] wd;
    logic [3:0]  id;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  tag_q[$];
  int          iss_cyc[$];
  logic [33:0] iss_cmd[$];
  int          n_iss = 0;
  int          n_rsp = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        due = 1'b0;
  logic [3:0]  due_id;
  logic [63:0] due_data;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [33:0] pack(
    logic w, logic [2:0] b, logic [13:0] r, logic [13:0] c);
    return {w, b, r, c, 2'b00};
  endfunction

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // monitor: responses, then issues, then returns
  always @(negedge clk) begin
    if (power_on_rst_n) begin
      if (rsp_valid || due) begin
        check("rsp_valid", 64'(rsp_valid), 64'(due));
        if (due) begin
          n_rsp++;
          check("rsp_id", 64'(rsp_id), 64'(due_id));
          check("rsp_rdata", rsp_rdata, due_data);
        end
      end
      due = 1'b0;
      if (valid) begin
        exp_t e;
        n_iss++;
        iss_cyc.push_back(cyc);
        iss_cmd.push_back(command);
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("command", 64'(command), 64'(e.cmd));
          if (e.w) check("write_data", write_data, e.wd);
          else     tag_q.push_back(e.id);
        end
      end
      if (read_data_valid && tag_q.size() > 0) begin
        due      = 1'b1;
        due_id   = tag_q.pop_front();
        due_data = read_data;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enq(logic w, logic [2:0] b, logic [13:0] r,
                     logic [13:0] c, logic [63:0] d,
                     logic [3:0] id);
    int n = 0;
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_bank  = b;
    req_row   = r;
    req_col   = c;
    req_wdata = d;
    req_id    = id;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    if (!req_ready) check("enq_ready", 64'(req_ready), 64'd1);
    e.w = w;
    e.cmd = pack(w, b, r, c);
    e.wd = d;
    e.id = id;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ret(logic [63:0] d);
    read_data       = d;
    read_data_valid = 1'b1;
    tick();
    read_data_valid = 1'b0;
  endtask

  task automatic wait_iss(int target, int budget);
    int n = 0;
    while (n_iss < target && n < budget) begin
      tick();
      n++;
    end
    check("issue_count", 64'(n_iss), 64'(target));
  endtask

  initial begin
    int b, c0, r0;
    power_on_rst_n  = 1'b0;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_bank        = '0;
    req_row         = '0;
    req_col         = '0;
    req_wdata       = '0;
    req_id          = '0;
    ba_cmd_pm       = 4'hF;
    read_data       = '0;
    read_data_valid = 1'b0;

    // reset state
    tick(3);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_command", 64'(command), 64'd0);
    check("rst_err", 64'(err_underflow), 64'd0);
    power_on_rst_n = 1'b1;
    #1;
    check("ready_pre_clk", 64'(req_ready), 64'd0);
    tick();
    check("ready_post_clk", 64'(req_ready), 64'd1);

    // write then read, bank 5
    b = n_iss;
    enq(1'b1, 3'd5, 14'h123, 14'h08, 64'hD00D_F00D_1234_5678, 4'd1);
    enq(1'b0, 3'd5, 14'h123, 14'h08, 64'h0, 4'd2);
    wait_iss(b + 2, 20);
    check("t2_wr_cmd", 64'(iss_cmd[b]), 64'h3_4123_0020);
    check("t2_rd_cmd", 64'(iss_cmd[b+1]), 64'h1_4123_0020);
    check("t2_gap", 64'(iss_cyc[b+1] - iss_cyc[b]), 64'd2);
    check("t2_wdata_hold", write_data, 64'hD00D_F00D_1234_5678);
    ret(64'hCAFE_BABE_0000_0001);
    check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t2_rsp_id", 64'(rsp_id), 64'd2);
    tick(2);

    // permit gating with head-of-line blocking
    ba_cmd_pm = 4'b1101;
    b = n_iss;
    enq(1'b0, 3'd2, 14'h055, 14'h003, 64'h0, 4'd3);
    enq(1'b1, 3'd0, 14'h001, 14'h002, 64'h1111_2222_3333_4444, 4'd4);
    tick(6);
    check("t3_blocked", 64'(n_iss - b), 64'd0);
    ba_cmd_pm = 4'hF;
    c0 = cyc;
    tick();
    check("t3_valid", 64'(valid), 64'd1);
    wait_iss(b + 2, 10);
    check("t3_latency", 64'(iss_cyc[b] - c0), 64'd1);
    ret(64'h0000_0000_0000_0333);
    tick(2);

    // fill with permits closed, then drain
    ba_cmd_pm = 4'h0;
    b = n_iss;
    for (int i = 0; i < 8; i++)
      enq(1'b1, 3'(i), 14'(i * 3), 14'(i + 5),
          64'(i) * 64'h0101_0101_0101_0101, 4'(i));
    check("t4_full", 64'(req_ready), 64'd0);
    ba_cmd_pm = 4'hF;
    wait_iss(b + 8, 40);
    for (int i = 1; i < 8; i++)
      check("t4_gap", 64'(iss_cyc[b+i] - iss_cyc[b+i-1]), 64'd2);

    // outstanding-read limit
    tick(2);
    b  = n_iss;
    r0 = n_rsp;
    for (int i = 0; i < 9; i++)
      enq(1'b0, 3'(i), 14'(i), 14'(2 * i), 64'h0, 4'(i));
    tick(20);
    check("t5_held", 64'(n_iss - b), 64'd8);
    ret(64'hA000_0000_0000_0000);
    wait_iss(b + 9, 10);
    tick(2);
    for (int i = 1; i < 9; i++)
      ret(64'hA000_0000_0000_0000 + 64'(i));
    tick(3);
    check("t5_rsp_count", 64'(n_rsp - r0), 64'd9);
    check("t5_tags_left", 64'(tag_q.size()), 64'd0);

    // spurious return
    check("t6_err_pre", 64'(err_underflow), 64'd0);
    ret(64'hBAD0_BAD0_BAD0_BAD0);
    check("t6_rsp", 64'(rsp_valid), 64'd0);
    check("t6_err", 64'(err_underflow), 64'd1);
    tick(5);
    check("t6_err_sticky", 64'(err_underflow), 64'd1);

    // reset mid-run drops queued and outstanding work
    b = n_iss;
    enq(1'b0, 3'd6, 14'h0AA, 14'h0BB, 64'h0, 4'd5);
    wait_iss(b + 1, 10);
    ba_cmd_pm = 4'h0;
    enq(1'b1, 3'd1, 14'h011, 14'h022, 64'h5555, 4'd6);
    tick();
    power_on_rst_n = 1'b0;
    #1;
    check("mid_valid", 64'(valid), 64'd0);
    check("mid_rsp", 64'(rsp_valid), 64'd0);
    check("mid_ready", 64'(req_ready), 64'd0);
    check("mid_command", 64'(command), 64'd0);
    check("mid_err", 64'(err_underflow), 64'd0);
    exp_q.delete();
    tag_q.delete();
    due = 1'b0;
    tick();
    power_on_rst_n = 1'b1;
    ba_cmd_pm = 4'hF;
    b = n_iss;
    tick(6);
    check("mid_dropped", 64'(n_iss - b), 64'd0);
    ret(64'h7777);
    check("mid_no_rsp", 64'(rsp_valid), 64'd0);
    check("mid_underflow", 64'(err_underflow), 64'd1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
